foo_intf_rr_arb: RTL and testbench



---
 rtl/foo_intf_rr_arb_if.sv | 13 +
 rtl/foo_intf_rr_arb.sv | 137 +++++++++++++
 tb/tb_foo_intf_rr_arb.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/foo_intf_rr_arb_if.sv
// Per-lane stream interface: valid/ready handshake carrying a data beat and a last flag.
// A beat transfers on a rising clk edge where valid && ready; the master holds data/last stable while valid && !ready.
interface foo_stream_intf #(
  parameter int W = 8
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;
  logic         last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/foo_intf_rr_arb.sv
// N-channel round-robin stream arbiter: 2-entry FIFO per channel, registered tagged output.
// Define FOO_RR_LOCK_EN to hold the grant on one channel until a beat with last=1 is granted.
module foo_intf_rr_arb #(
  parameter  int NCH = 4,
  parameter  int W   = 8,
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  foo_stream_intf.slave   chans [0:NCH-1],
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic            out_last,
  output logic [CW-1:0]   out_chan,
  output logic            busy
);

  logic [NCH-1:0] w_ne;
  logic [NCH-1:0] w_hd_last;
  logic [W-1:0]   w_hd_data [NCH];

  logic           r_out_valid;
  logic           r_out_last;
  logic [W-1:0]   r_out_data;
  logic [CW-1:0]  r_out_chan;
  logic [CW-1:0]  r_ptr;

  logic           w_load;
  logic           w_grant;
  logic           w_found;
  logic [CW-1:0]  w_gidx;
  logic           w_rr_found;
  logic [CW-1:0]  w_rr_idx;
  logic [CW-1:0]  w_scan;

  assign w_load  = !r_out_valid || out_ready;
  assign w_grant = w_load && w_found;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [W:0] r_mem [2];
    logic       r_rd;
    logic       r_wr;
    logic [1:0] r_cnt;
    logic       w_push;
    logic       w_pop;

    // ready is a pure function of occupancy so it never combinationally depends on the output side
    assign chans[g].ready = (r_cnt != 2'd2);
    assign w_push         = chans[g].valid && (r_cnt != 2'd2);
    assign w_pop          = w_grant && (w_gidx == CW'(g));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rd  <= 1'b0;
        r_wr  <= 1'b0;
        r_cnt <= 2'd0;
      end else begin
        if (w_push) r_wr <= ~r_wr;
        if (w_pop)  r_rd <= ~r_rd;
        case ({w_push, w_pop})
          2'b10:   r_cnt <= r_cnt + 2'd1;
          2'b01:   r_cnt <= r_cnt - 2'd1;
          default: r_cnt <= r_cnt;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= {chans[g].last, chans[g].data};
    end

    assign w_ne[g]      = (r_cnt != 2'd0);
    assign w_hd_data[g] = r_mem[r_rd][W-1:0];
    assign w_hd_last[g] = r_mem[r_rd][W];
  end

  // Scan from farthest to nearest so the closest non-empty channel after r_ptr wins.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    w_scan     = '0;
    for (int k = NCH; k >= 1; k--) begin
      w_scan = CW'((int'(r_ptr) + k) % NCH);
      if (w_ne[w_scan]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = w_scan;
      end
    end
  end

`ifdef FOO_RR_LOCK_EN
  logic          r_lock;
  logic [CW-1:0] r_lock_ch;

  assign w_found = r_lock ? w_ne[r_lock_ch] : w_rr_found;
  assign w_gidx  = r_lock ? r_lock_ch       : w_rr_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock    <= 1'b0;
      r_lock_ch <= '0;
    end else if (w_grant) begin
      r_lock    <= !w_hd_last[w_gidx];
      r_lock_ch <= w_gidx;
    end
  end
`else
  assign w_found = w_rr_found;
  assign w_gidx  = w_rr_idx;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_chan  <= '0;
      r_ptr       <= CW'(NCH - 1);
    end else if (w_load) begin
      r_out_valid <= w_found;
      if (w_found) begin
        r_out_data <= w_hd_data[w_gidx];
        r_out_last <= w_hd_last[w_gidx];
        r_out_chan <= w_gidx;
        r_ptr      <= w_gidx;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_chan  = r_out_chan;
  assign busy      = r_out_valid || (|w_ne);

endmodule

// File: tb/tb_foo_intf_rr_arb.sv
// Bench for foo_intf_rr_arb: queue-level reference model feeding a scoreboard, directed scenarios plus random traffic.
module tb_foo_intf_rr_arb;
  localparam int NCH = 4;
  localparam int W   = 8;
  localparam int CW  = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main DUT
  foo_stream_intf #(.W(W)) chans [0:NCH-1] ();
  logic [NCH-1:0] drv_valid;
  logic [NCH-1:0] drv_last;
  logic [W-1:0]   drv_data [NCH];
  logic [NCH-1:0] mon_ready;
  logic           out_valid, out_ready, out_last, busy;
  logic [W-1:0]   out_data;
  logic [CW-1:0]  out_chan;

  for (genvar g = 0; g < NCH; g++) begin : g_conn
    assign chans[g].valid = drv_valid[g];
    assign chans[g].data  = drv_data[g];
    assign chans[g].last  = drv_last[g];
    assign mon_ready[g]   = chans[g].ready;
  end

  foo_intf_rr_arb #(.NCH(NCH), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .chans(chans),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_chan(out_chan), .busy(busy)
  );

  // single-channel, 1-bit DUT
  foo_stream_intf #(.W(1)) c1 [0:0] ();
  logic       v1 = 1'b0, l1 = 1'b1, r1rdy;
  logic [0:0] d1 = 1'b0;
  logic       ov1, ol1, busy1;
  logic [0:0] od1, oc1;
  logic       or1 = 1'b1;
  assign c1[0].valid = v1;
  assign c1[0].data  = d1;
  assign c1[0].last  = l1;
  assign r1rdy       = c1[0].ready;

  foo_intf_rr_arb #(.NCH(1), .W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .chans(c1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1),
    .out_last(ol1), .out_chan(oc1), .busy(busy1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // driver state
  logic [W:0] src_q [NCH][$];
  logic [NCH-1:0] hs;
  bit   rnd_ready = 0;
  bit   gap_en = 0;
  logic fix_ready = 1'b0;

  // reference model: per-channel queues, output slot, rotating pointer
  logic [W:0]      mq [NCH][$];
  logic [CW+W:0]   exp_q [$];
  bit              m_ov;
  int              m_ptr;
  bit              m_lock;
  int              m_lock_ch;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) mq[i].delete();
      exp_q.delete();
      m_ov = 0; m_ptr = NCH - 1; m_lock = 0; m_lock_ch = 0;
    end else begin
      bit [NCH-1:0] pre_rdy;
      bit           found;
      int           c;
      logic [W:0]   b;
      for (int i = 0; i < NCH; i++) pre_rdy[i] = (mq[i].size() < 2);
      if (!m_ov || out_ready) begin
        found = 0; c = 0;
        if (m_lock) begin
          c = m_lock_ch;
          found = (mq[c].size() > 0);
        end else begin
          for (int k = 1; k <= NCH && !found; k++) begin
            if (mq[(m_ptr + k) % NCH].size() > 0) begin
              found = 1;
              c = (m_ptr + k) % NCH;
            end
          end
        end
        if (found) begin
          b = mq[c].pop_front();
          m_ov = 1;
          m_ptr = c;
          exp_q.push_back({CW'(c), b});
`ifdef FOO_RR_LOCK_EN
          m_lock = !b[W];
          m_lock_ch = c;
`endif
        end else begin
          m_ov = 0;
        end
      end
      for (int i = 0; i < NCH; i++)
        if (drv_valid[i] && pre_rdy[i]) mq[i].push_back({drv_last[i], drv_data[i]});
    end
  end

  // monitor / scoreboard
  bit                 rec_en = 0;
  logic [CW+W-1:0]    rec_q [$];
  logic [0:0]         q1 [$];

  always @(negedge clk) begin
    if (rst_n) begin
      logic [NCH-1:0] exp_rdy;
      bit any;
      any = 0;
      for (int i = 0; i < NCH; i++) begin
        exp_rdy[i] = (mq[i].size() < 2);
        if (mq[i].size() > 0) any = 1;
      end
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      chk("ready", 32'(mon_ready), 32'(exp_rdy));
      chk("busy", 32'(busy), 32'(m_ov || any));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat actual=%0h expected=none", {out_chan, out_last, out_data});
        end else begin
          chk("beat", 32'({out_chan, out_last, out_data}), 32'(exp_q.pop_front()));
        end
        if (rec_en) rec_q.push_back({out_chan, out_data});
      end
      if (ov1 && or1) begin
        q1.push_back(od1);
        chk("nch1_chan", 32'(oc1), 32'd0);
      end
    end
  end

  // driver tasks
  task automatic feed();
    for (int i = 0; i < NCH; i++) begin
      if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      if (drv_valid[i] && !hs[i]) begin
        // hold the offered beat until it is accepted
      end else if (src_q[i].size() > 0 && (!gap_en || $urandom_range(0, 2) != 0)) begin
        drv_valid[i] = 1'b1;
        {drv_last[i], drv_data[i]} = src_q[i][0];
      end else begin
        drv_valid[i] = 1'b0;
      end
    end
    out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : fix_ready;
  endtask

  task automatic tick();
    for (int i = 0; i < NCH; i++) hs[i] = drv_valid[i] && mon_ready[i];
    @(posedge clk);
    #1;
    feed();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input int ch, input logic last, input logic [W-1:0] data);
    src_q[ch].push_back({last, data});
  endtask

  initial begin
    logic [3:0] pat;
    bit done;
    drv_valid = '0; drv_last = '0; out_ready = 1'b0; hs = '0;
    for (int i = 0; i < NCH; i++) drv_data[i] = '0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_chan", 32'(out_chan), 32'd0);
    chk("rst_ready", 32'(mon_ready), 32'hF);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ticks(2);

    // round robin: two beats per channel staged under backpressure
    fix_ready = 1'b0;
    for (int n = 0; n < 2; n++)
      for (int i = 0; i < NCH; i++) push(i, 1'b1, W'(16 * i + n));
    ticks(5);
    rec_q.delete(); rec_en = 1; fix_ready = 1'b1;
    ticks(12);
    rec_en = 0;
    chk("rr_count", 32'(rec_q.size()), 32'd8);
    for (int n = 0; n < 8 && n < rec_q.size(); n++)
      chk("rr_seq", 32'(rec_q[n]), 32'({CW'(n % 4), W'(16 * (n % 4) + n / 4)}));

    // single channel, latency and no gaps
    push(2, 1'b1, 8'h11); push(2, 1'b1, 8'h22); push(2, 1'b1, 8'h33);
    tick(); chk("lat_e1", 32'(out_valid), 32'd0);
    tick(); chk("lat_e2", 32'(out_valid), 32'd0);
    tick(); chk("single_b0", 32'({out_valid, out_chan, out_data}), 32'({1'b1, 2'd2, 8'h11}));
    tick(); chk("single_b1", 32'({out_valid, out_chan, out_data}), 32'({1'b1, 2'd2, 8'h22}));
    tick(); chk("single_b2", 32'({out_valid, out_chan, out_data}), 32'({1'b1, 2'd2, 8'h33}));
    tick(); chk("single_end", 32'(out_valid), 32'd0);

    // backpressure on ch0
    fix_ready = 1'b0;
    for (int n = 0; n < 5; n++) push(0, 1'b1, W'(8'hA0 + n));
    ticks(4);
    for (int n = 0; n < 3; n++) begin
      chk("bp_ready0", 32'(mon_ready[0]), 32'd0);
      chk("bp_hold", 32'({out_valid, out_data}), 32'({1'b1, 8'hA0}));
      tick();
    end
    rec_q.delete(); rec_en = 1; fix_ready = 1'b1;
    ticks(12);
    rec_en = 0;
    chk("bp_count", 32'(rec_q.size()), 32'd5);
    for (int n = 0; n < 5 && n < rec_q.size(); n++)
      chk("bp_seq", 32'(rec_q[n]), 32'({2'd0, W'(8'hA0 + n)}));

    // reset mid-traffic with beats buffered in ch1
    fix_ready = 1'b0;
    for (int n = 0; n < 3; n++) push(1, 1'b1, W'(8'h50 + n));
    ticks(6);
    rst_n = 1'b0;
    for (int i = 0; i < NCH; i++) src_q[i].delete();
    drv_valid = '0; hs = '0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(mon_ready), 32'hF);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    ticks(2);
    rst_n = 1'b1;
    fix_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("post_rst_idle", 32'({out_valid, busy}), 32'd0);
    end

    // packet lock: ch0 A,B,C(last) vs ch1 D
    fix_ready = 1'b0;
    push(0, 1'b0, 8'hA1); push(0, 1'b0, 8'hB2); push(0, 1'b1, 8'hC3);
    push(1, 1'b1, 8'hD4);
    ticks(5);
    rec_q.delete(); rec_en = 1; fix_ready = 1'b1;
    ticks(10);
    rec_en = 0;
    chk("lock_count", 32'(rec_q.size()), 32'd4);
    if (rec_q.size() == 4) begin
`ifdef FOO_RR_LOCK_EN
      chk("lock_seq", 32'({rec_q[0][7:0], rec_q[1][7:0], rec_q[2][7:0], rec_q[3][7:0]}), 32'hA1B2C3D4);
`else
      chk("lock_seq", 32'({rec_q[0][7:0], rec_q[1][7:0], rec_q[2][7:0], rec_q[3][7:0]}), 32'hA1D4B2C3);
`endif
    end

    // random traffic against the model
    rnd_ready = 1; gap_en = 1;
    for (int c = 0; c < 1500; c++) begin
      tick();
      for (int i = 0; i < NCH; i++)
        if (src_q[i].size() < 3 && $urandom_range(0, 3) == 0)
          push(i, 1'($urandom_range(0, 1)), W'($urandom_range(0, 255)));
    end
    for (int i = 0; i < NCH; i++) push(i, 1'b1, W'($urandom_range(0, 255)));
    done = 0;
    for (int c = 0; c < 600 && !done; c++) begin
      tick();
      done = 1;
      for (int i = 0; i < NCH; i++) if (src_q[i].size() > 0 || drv_valid[i]) done = 0;
      if (busy || exp_q.size() > 0) done = 0;
    end
    chk("drain_done", 32'(done), 32'd1);
    rnd_ready = 0; fix_ready = 1'b1;

    // NCH=1, W=1 passthrough
    pat = 4'b1010;
    q1.delete();
    for (int n = 0; n < 4; n++) begin
      bit acc;
      v1 = 1'b1; d1 = pat[n];
      acc = 0;
      for (int k = 0; k < 20 && !acc; k++) begin
        acc = r1rdy;
        @(posedge clk); #1;
      end
    end
    v1 = 1'b0;
    ticks(6);
    chk("nch1_count", 32'(q1.size()), 32'd4);
    for (int n = 0; n < 4 && n < q1.size(); n++) begin
      logic [0:0] b;
      b = pat[n];
      chk("nch1_data", 32'(q1[n]), 32'(b));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
